// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops async-FIFO words into a 2-entry buffer and streams them out (valid/ready).
// Optional starvation counter enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DSIZE = 32,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    input  logic             almost_empty,
    output logic             rinc,
    input  logic             en,
    input  logic             flush,
    output logic             flush_done,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             low_water,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    state_t             base_next_s;
    logic [1:0]         cnt_r;
    logic [DSIZE-1:0]   buf0_r;
    logic [DSIZE-1:0]   buf1_r;
    logic               rinc_s;
    logic               drain_s;
    logic               push_s;
    logic               flush_done_s;
    logic               low_water_r;
    logic [CNT_W-1:0]   word_cnt_r;

    // The head entry is always buf0_r; flushing hides the buffer immediately.
    assign m_valid    = (cnt_r != 2'd0) && (state_r != ST_FLUSH);
    assign m_data     = buf0_r;
    assign drain_s    = m_valid & m_ready;
    assign push_s     = rinc_s & (state_r == ST_RUN);
    assign rinc       = rinc_s;
    assign flush_done = flush_done_s;
    assign low_water  = low_water_r;
    assign word_cnt   = word_cnt_r;

    // Next-state, pop strobe and flush completion decode.
    always_comb begin
        base_next_s  = state_r;
        rinc_s       = 1'b0;
        flush_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    base_next_s = ST_RUN;
                end else begin
                    base_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rinc_s = ~rempty & ((cnt_r < 2'd2) | drain_s);
                if (en) begin
                    base_next_s = ST_RUN;
                end else begin
                    base_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                rinc_s = ~rempty;
                // A flush still being requested keeps draining even if the FIFO looks empty.
                if (rempty && !flush) begin
                    flush_done_s = 1'b1;
                    base_next_s  = en ? ST_RUN : ST_IDLE;
                end else begin
                    base_next_s  = ST_FLUSH;
                end
            end
            default: begin
                base_next_s = ST_IDLE;
            end
        endcase
        if (flush) begin
            next_state_s = ST_FLUSH;
        end else begin
            next_state_s = base_next_s;
        end
    end

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Two-entry buffer; a simultaneous push and drain queues the new word behind the survivor.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_r  <= 2'd0;
            buf0_r <= {DSIZE{1'b0}};
            buf1_r <= {DSIZE{1'b0}};
        end else if (flush || (state_r == ST_FLUSH)) begin
            cnt_r <= 2'd0;
        end else begin
            case ({push_s, drain_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        buf0_r <= rdata;
                    end else begin
                        buf1_r <= rdata;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    buf0_r <= buf1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        buf0_r <= rdata;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= rdata;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Delivered-word counter and registered almost-empty status.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt_r  <= {CNT_W{1'b0}};
            low_water_r <= 1'b0;
        end else begin
            low_water_r <= almost_empty;
            if (drain_s) begin
                word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where the consumer is ready but nothing is buffered.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (flush && (state_r != ST_FLUSH)) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && m_ready && !m_valid &&
                     (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised scoreboard bench for fifo_rd_stream with a queue-based FIFO model feeding the read port.
module tb_fifo_rd_stream;
    localparam int DSIZE = 32;
    localparam int CNT_W = 16;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             almost_empty;
    logic             rinc;
    logic             en;
    logic             flush;
    logic             flush_done;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             low_water;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] stall_cnt;

    fifo_rd_stream #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
        .almost_empty(almost_empty), .rinc(rinc), .en(en), .flush(flush),
        .flush_done(flush_done), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .low_water(low_water), .word_cnt(word_cnt),
        .stall_cnt(stall_cnt)
    );

    always #5 rclk = ~rclk;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    int               hs_cyc_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               cyc = 0;
    int               fd_pulses = 0;
    int               n_written = 0;
    bit               pop_pending = 1'b0;
    bit               ae_edge = 1'b0;
    bit               edge_ok = 1'b0;
    bit               hold_pend = 1'b0;
    logic [DSIZE-1:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : {DSIZE{1'b0}};
    endtask

    task automatic fifo_write(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        n_written++;
        refresh();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    // FIFO model: perform the pop the DUT requested on this edge.
    always @(posedge rclk) begin
        cyc++;
        ae_edge = almost_empty;
        edge_ok = rrst_n;
        #1;
        if (pop_pending && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        pop_pending = 1'b0;
        refresh();
    end

    // Monitor: sample everything mid-cycle, score each handshake against the expected queue.
    always @(negedge rclk) begin
        if (rrst_n) begin
            pop_pending = rinc;
            if (rinc) check("rinc_on_empty", 64'(rempty), 64'(0));
            if (hold_pend) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", 64'(m_data), 64'(hold_data));
            end
            if (m_valid && m_ready) begin
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_word: got %0h expected none (cycle %0d)", m_data, cyc);
                end else begin
                    check("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
            hold_pend = m_valid && !m_ready && !flush;
            hold_data = m_data;
            if (flush_done) fd_pulses++;
            if (edge_ok) check("low_water", 64'(low_water), 64'(ae_edge));
        end else begin
            pop_pending = 1'b0;
            hold_pend   = 1'b0;
        end
    end

    int k;
    int wc0;

    initial begin
        en = 1'b0; flush = 1'b0; m_ready = 1'b0; almost_empty = 1'b0; rrst_n = 1'b0;
        refresh();
        step(2);
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_rinc", 64'(rinc), 64'(0));
        check("rst_flush_done", 64'(flush_done), 64'(0));
        check("rst_low_water", 64'(low_water), 64'(0));
        check("rst_word_cnt", 64'(word_cnt), 64'(0));
        check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        rrst_n = 1'b1;

        // Burst: eight words, one per cycle, first one cycle after rempty falls.
        en = 1'b1; m_ready = 1'b1;
        step(2);
        hs_cyc_q.delete();
        k = cyc;
        for (int i = 0; i < 8; i++) fifo_write(32'h10 + 32'(i));
        step(12);
        check("burst_count", 64'(hs_cyc_q.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            check("burst_cycle", 64'((i < hs_cyc_q.size()) ? hs_cyc_q[i] : -1), 64'(k + 1 + i));
        check("burst_word_cnt", 64'(word_cnt), 64'(8));

        // Backpressure: buffer fills to two, pop stops, head held.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(32'hA0 + 32'(i));
        step(5);
        check("bp_valid", 64'(m_valid), 64'(1));
        check("bp_rinc", 64'(rinc), 64'(0));
        check("bp_head", 64'(m_data), 64'(32'hA0));
        check("bp_fifo_left", 64'(fifo_q.size()), 64'(2));
        m_ready = 1'b1;
        step(8);
        check("bp_all_out", 64'(exp_q.size()), 64'(0));
        check("bp_word_cnt", 64'(word_cnt), 64'(12));

        // Disable: buffered pair still drains, FIFO untouched afterwards.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(32'hB0 + 32'(i));
        step(4);
        en = 1'b0;
        step(1);
        m_ready = 1'b1;
        step(4);
        check("dis_valid", 64'(m_valid), 64'(0));
        check("dis_rinc", 64'(rinc), 64'(0));
        check("dis_fifo_left", 64'(fifo_q.size()), 64'(2));
        check("dis_word_cnt", 64'(word_cnt), 64'(14));
        en = 1'b1;
        step(6);
        check("dis_resume", 64'(exp_q.size()), 64'(0));

        // Flush: discard the buffer, drain the FIFO, single completion pulse.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_write(32'hC0 + 32'(i));
        step(4);
        wc0 = int'(word_cnt);
        fd_pulses = 0;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        exp_q.delete();
        check("flush_valid", 64'(m_valid), 64'(0));
        step(10);
        check("flush_pulses", 64'(fd_pulses), 64'(1));
        check("flush_fifo_empty", 64'(fifo_q.size()), 64'(0));
        check("flush_word_cnt", 64'(word_cnt), 64'(wc0));
        m_ready = 1'b1;
        fifo_write(32'hD0);
        step(4);
        check("post_flush", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset while a push and a drain are both in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(32'hE0 + 32'(i));
        step(3);
        m_ready = 1'b1;
        #1;
        check("pre_rst_rinc", 64'(rinc), 64'(1));
        rrst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'(0));
        check("mid_rst_rinc", 64'(rinc), 64'(0));
        check("mid_rst_word_cnt", 64'(word_cnt), 64'(0));
        fifo_q.delete();
        exp_q.delete();
        refresh();
        n_written = 0;
        edge_ok = 1'b0;
        step(2);
        rrst_n = 1'b1;

        // Starvation: RUN, ready, empty FIFO for ten cycles.
        en = 1'b1; m_ready = 1'b1;
        step(11);
`ifdef FIFO_RD_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(10));
`else
        check("stall_cnt", 64'(stall_cnt), 64'(0));
`endif

        // Random traffic against the order-preserving reference.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_write($urandom);
            m_ready      = ($urandom_range(0, 3) != 0);
            en           = ($urandom_range(0, 9) != 0);
            almost_empty = $urandom_range(0, 1) == 1;
            step(1);
        end
        en = 1'b1; m_ready = 1'b1;
        step(40);
        check("rand_all_out", 64'(exp_q.size()), 64'(0));
        check("rand_word_cnt", 64'(word_cnt), 64'(n_written % 65536));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO, clocked in the read domain.
- Pops words from the FIFO read port (rdata/rempty/rinc) into a 2-entry output buffer and presents them as a valid/ready stream.
- Provides a flush sequence that discards buffered words and drains the FIFO contents visible at that time.
- Counts delivered words.

Parameters:
- DSIZE, 32, data word width; matches FIFO DSIZE.
- CNT_W, 16, width of word_cnt and stall_cnt.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset
- rdata  input  DSIZE  FIFO head word; valid combinationally whenever rempty=0
- rempty  input  1  FIFO empty flag (read domain)
- almost_empty  input  1  FIFO almost-empty flag; status only
- rinc  output  1  FIFO pop strobe; one word consumed per rclk edge with rinc=1
- en  input  1  1 = fetch from FIFO; 0 = stop fetching, buffer still drains
- flush  input  1  single-cycle or level request to discard and drain
- flush_done  output  1  one-cycle pulse at flush completion
- m_data  output  DSIZE  stream data (buffer head)
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready
- low_water  output  1  registered copy of almost_empty
- word_cnt  output  CNT_W  count of stream handshakes
- stall_cnt  output  CNT_W  starvation cycles (optional feature)

Behaviour:
- Clock/reset: one clock, rclk. Reset is asynchronous, active-low (rrst_n).
- Reset values: state=IDLE, buffer count=0, m_valid=0, m_data=0, rinc=0, flush_done=0, low_water=0, word_cnt=0, stall_cnt=0.
- FSM states:
  - IDLE: en=0.
  - RUN: fetching.
  - FLUSH: discarding.
- FSM transitions:
  - flush=1 in any state -> FLUSH next cycle (highest priority).
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - FLUSH -> (en ? RUN : IDLE) on the first cycle with rempty=1 and flush=0; flush_done=1 on that same cycle.
- Buffer:
  - 2 entries, cnt in {0,1,2}. m_valid = (cnt!=0) and state!=FLUSH. m_data = head entry; held stable while m_valid=1 and m_ready=0.
  - drain = m_valid & m_ready.
  - RUN: rinc = ~rempty & (cnt<2 | drain). Combinational output.
  - IDLE: rinc=0.
  - FLUSH: rinc = ~rempty.
  - Push (RUN only): on rinc, rdata is captured at the same edge. Simultaneous push and drain leaves cnt unchanged; the new word goes behind the remaining entry.
  - Latency: word visible in FIFO (rempty=0) with cnt=0 and RUN -> m_valid=1 on the next cycle.
  - Full throughput: one word per cycle when rempty=0 and m_ready=1 continuously.
- Order preserved: words leave in FIFO pop order, with no duplication and no loss outside FLUSH.
- FLUSH:
  - Entering FLUSH clears cnt to 0 at the transition edge.
  - Popped words are discarded.
  - Words written to the FIFO after rempty is observed high are not drained.
- en falling mid-stream: the in-flight pop on that edge completes; buffered words still drain in IDLE.
- word_cnt: increments on each drain, wraps modulo 2^CNT_W; cleared only by reset.
- low_water: almost_empty registered by 1 cycle.
- Reset mid-operation: all state returns to reset values immediately; buffered words are lost.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- Defined: stall_cnt increments each cycle with state=RUN, m_ready=1, m_valid=0. Saturates at 2^CNT_W-1. Cleared by reset and by entry to FLUSH.
- Undefined: stall_cnt tied to 0; no counter logic.

Test Plan:
- Burst: reset, en=1, FIFO preloaded with 0x10..0x17, m_ready=1 -> m_data 0x10..0x17 on 8 consecutive cycles, first one cycle after rempty falls; word_cnt=8.
- Backpressure: 4 words queued, m_ready=0 for 5 cycles -> cnt=2, rinc=0, m_data holds the first word. Then m_ready=1 -> all 4 words delivered in order, none lost.
- Disable: en=0 with cnt=2, m_ready=1 -> 2 words delivered, then m_valid=0, rinc stays 0 while rempty=0.
- Flush: 6 words in FIFO, cnt=2, flush pulse -> m_valid=0 next cycle, rinc high until rempty=1, flush_done single pulse, word_cnt unchanged, FIFO empty.
- Reset mid-stream: rrst_n low while cnt=2 and rinc=1 -> m_valid=0, rinc=0, word_cnt=0 immediately (asynchronous).
- Stats (FIFO_RD_STATS_EN): RUN, m_ready=1, FIFO empty for 10 cycles -> stall_cnt=10. Without the macro, stall_cnt=0.
